lcd_refresh_ctrl: RTL

- Sequencer for the board's 16x2 HD44780-compatible character LCD (8-bit bus, write-only).
- Runs the power-up init sequence, then on request rewrites all 32 character cells from an internal 32x8 character buffer.
- Sits between application logic (buffer writes, refresh requests) and the LCD_DATA/LCD_RW/LCD_EN/LCD_RS pins at the top level.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_refresh_ctrl_if.sv | 24 ++
 rtl/lcd_byte_writer.sv | 81 ++++++++
 rtl/lcd_refresh_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 refresh sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwr,
    StInit,
    StIdle,
    StLine0,
    StLine1
  } state_e;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY      = 8'h06;
  localparam logic [7:0] LINE0_BASE = 8'h80;
  localparam logic [7:0] LINE1_BASE = 8'hC0;

  // Power-up command sequence, entry 0 sent first.
  localparam logic [3:0][7:0] INIT_ROM = {ENTRY, CLEAR, DISP_ON, FUNC_SET};

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear-display is the only byte that needs the long settle time.
  function automatic logic is_clear(input logic rs, input logic [7:0] data);
    return !rs && (data == CLEAR);
  endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_if.sv
// Application-side and LCD-pin signals of the refresh sequencer.
interface lcd_refresh_ctrl_if;
  logic       char_we;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       refresh;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] lcd_data;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_rs;

  modport master (
    output char_we, char_addr, char_data, refresh,
    input  ready, busy, done, lcd_data, lcd_rw, lcd_en, lcd_rs
  );

  modport slave (
    input  char_we, char_addr, char_data, refresh,
    output ready, busy, done, lcd_data, lcd_rw, lcd_en, lcd_rs
  );
endinterface

// File: rtl/lcd_byte_writer.sv
// Runs one SETUP/PULSE/WAIT byte transaction on the LCD bus.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned EN_PULSE = 12,
  parameter int unsigned CMD_WAIT = 2000,
  parameter int unsigned CLR_WAIT = 82000,
  parameter int unsigned CntW     = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       byte_rs,
  input  logic [7:0] byte_data,
  input  logic       long_wait,
  output logic       done,
  output logic       en,
  output logic       rs,
  output logic [7:0] data
);

  typedef enum logic [1:0] {WrIdle, WrSetup, WrPulse, WrWait} wr_state_e;

  wr_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            long_q;

  // Last WAIT cycle; a start seen here chains straight into the next SETUP.
  assign done = (state_q == WrWait) && (cnt_q == '0);

  // Byte sequencer; RS/DATA only change when a new byte is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WrIdle;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      en      <= 1'b0;
      rs      <= 1'b0;
      data    <= 8'h00;
    end else begin
      unique case (state_q)
        WrIdle: begin
          if (start) begin
            state_q <= WrSetup;
            rs      <= byte_rs;
            data    <= byte_data;
            long_q  <= long_wait;
          end
        end
        WrSetup: begin
          state_q <= WrPulse;
          en      <= 1'b1;
          cnt_q   <= CntW'(EN_PULSE - 1);
        end
        WrPulse: begin
          if (cnt_q == '0) begin
            state_q <= WrWait;
            en      <= 1'b0;
            cnt_q   <= long_q ? CntW'(CLR_WAIT - 1) : CntW'(CMD_WAIT - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WrWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (start) begin
            state_q <= WrSetup;
            rs      <= byte_rs;
            data    <= byte_data;
            long_q  <= long_wait;
          end else begin
            state_q <= WrIdle;
          end
        end
        default: state_q <= WrIdle;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 sequencer: power-up init, then full-screen rewrite from a 32-cell buffer.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWR_WAIT = 750000,
  parameter int unsigned EN_PULSE = 12,
  parameter int unsigned CMD_WAIT = 2000,
  parameter int unsigned CLR_WAIT = 82000
) (
  input logic          clk,
  input logic          rst_n,
  lcd_refresh_ctrl_if.slave bus
);

  localparam int unsigned MaxCnt = max_u(max_u(PWR_WAIT, CLR_WAIT), max_u(CMD_WAIT, EN_PULSE));
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  state_e          state_q;
  logic [CntW-1:0] wait_q;
  logic [4:0]      idx_q;     // init step, or cell currently on the bus
  logic            cmd_q;     // byte on the bus is the line-address command
  logic            pending_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      cell_q [32];

  logic       start;
  logic       byte_rs;
  logic [7:0] byte_data;
  logic       wr_done;
  logic [4:0] rd_addr;

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.lcd_rw = 1'b0;

  // Pick the next byte so it launches right as the previous WAIT ends.
  always_comb begin
    start     = 1'b0;
    byte_rs   = 1'b0;
    byte_data = 8'h00;
    rd_addr   = cmd_q ? idx_q : idx_q + 5'd1;
    unique case (state_q)
      StPwr: begin
        if (wait_q == '0) begin
          start     = 1'b1;
          byte_data = INIT_ROM[0];
        end
      end
      StInit: begin
        if (wr_done && idx_q != 5'd3) begin
          start     = 1'b1;
          byte_data = INIT_ROM[idx_q[1:0] + 2'd1];
        end
      end
      StIdle: begin
        if (bus.refresh || pending_q) begin
          start     = 1'b1;
          byte_data = LINE0_BASE;
        end
      end
      StLine0: begin
        if (wr_done) begin
          start = 1'b1;
          if (cmd_q || idx_q != 5'd15) begin
            byte_rs   = 1'b1;
            byte_data = cell_q[rd_addr];
          end else begin
            byte_data = LINE1_BASE;
          end
        end
      end
      StLine1: begin
        if (wr_done && (cmd_q || idx_q != 5'd31)) begin
          start     = 1'b1;
          byte_rs   = 1'b1;
          byte_data = cell_q[rd_addr];
        end
      end
      default: ;
    endcase
  end

  // Main sequencer: power wait, init commands, idle, two line passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPwr;
      wait_q    <= CntW'(PWR_WAIT - 1);
      idx_q     <= 5'd0;
      cmd_q     <= 1'b0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.refresh && state_q != StIdle) pending_q <= 1'b1;
      unique case (state_q)
        StPwr: begin
          if (wait_q == '0) begin
            state_q <= StInit;
            idx_q   <= 5'd0;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StInit: begin
          if (wr_done) begin
            if (idx_q == 5'd3) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        StIdle: begin
          if (bus.refresh || pending_q) begin
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StLine0;
            idx_q     <= 5'd0;
            cmd_q     <= 1'b1;
          end
        end
        StLine0: begin
          if (wr_done) begin
            if (cmd_q) begin
              cmd_q <= 1'b0;
            end else if (idx_q == 5'd15) begin
              state_q <= StLine1;
              idx_q   <= 5'd16;
              cmd_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        StLine1: begin
          if (wr_done) begin
            if (cmd_q) begin
              cmd_q <= 1'b0;
            end else if (idx_q == 5'd31) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        default: state_q <= StPwr;
      endcase
    end
  end

  // Character buffer; a write and a read of the same cell in one cycle yields the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
    end else if (bus.char_we) begin
      cell_q[bus.char_addr] <= bus.char_data;
    end
  end

  lcd_byte_writer #(
    .EN_PULSE (EN_PULSE),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT),
    .CntW     (CntW)
  ) u_writer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_rs   (byte_rs),
    .byte_data (byte_data),
    .long_wait (is_clear(byte_rs, byte_data)),
    .done      (wr_done),
    .en        (bus.lcd_en),
    .rs        (bus.lcd_rs),
    .data      (bus.lcd_data)
  );

endmodule
